// File: rtl/parking_pkg.sv
// Shared definitions for the time-scheduled parking manager: hour encoding,
// car class and the hour-dependent university capacity schedule.
package parking_pkg;

    localparam int HOUR_W        = 5;
    localparam int HOURS_PER_DAY = 24;

    typedef enum logic {
        CLS_GEN = 1'b0,
        CLS_UNI = 1'b1
    } cls_e;

    // University capacity for a given hour. Evaluated in signed 32-bit
    // arithmetic so a large reduction clamps at the floor instead of wrapping.
    function automatic int uni_cap_of_hour(
        input int hour,
        input int cap_start,
        input int cap_step,
        input int cap_end,
        input int step_hour
    );
        int cap;
        if (hour < step_hour) begin
            cap = cap_start;
        end else begin
            cap = cap_start - cap_step * (hour - step_hour + 1);
            if (cap < cap_end) begin
                cap = cap_end;
            end
        end
        return cap;
    endfunction

endpackage

// File: rtl/parking_hour_clock.sv
// Simulated time of day: divides the clock into hours and counts hours 0..23,
// starting from a configurable hour after reset.
module parking_hour_clock
    import parking_pkg::*;
#(
    parameter int CYCLES_PER_HOUR = 3600,
    parameter int START_HOUR      = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [HOUR_W-1:0] hour,
    output logic              hour_tick
);

    localparam int TICK_W = $clog2(CYCLES_PER_HOUR);

    logic [TICK_W-1:0] tick;

    assign hour_tick = (tick == TICK_W'(CYCLES_PER_HOUR - 1));

    // Cycle counter within the current hour, wrapping at the end of the hour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick <= '0;
        end else if (hour_tick) begin
            tick <= '0;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    // Hour of day, advancing once per wrap of the tick counter, 23 rolls to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hour <= HOUR_W'(START_HOUR);
        end else if (hour_tick) begin
            hour <= (hour == HOUR_W'(HOURS_PER_DAY - 1)) ? '0 : hour + 1'b1;
        end
    end

endmodule

// File: rtl/parking_manager_sched.sv
// Parking occupancy manager with an hourly shrinking university share.
// Admits or denies entries, rejects exits of an empty class and reports the
// free space per class from the registered counts and the current hour.
module parking_manager_sched
    import parking_pkg::*;
#(
    parameter int COUNT_W         = 10,
    parameter int TOTAL_CAP       = 700,
    parameter int UNI_CAP_START   = 500,
    parameter int UNI_CAP_STEP    = 50,
    parameter int UNI_CAP_END     = 200,
    parameter int STEP_HOUR       = 13,
    parameter int START_HOUR      = 8,
    parameter int CYCLES_PER_HOUR = 3600
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               entry_req,
    input  logic               entry_is_uni,
    input  logic               exit_req,
    input  logic               exit_is_uni,
    output logic               entry_ack,
    output logic               entry_granted,
    output logic               exit_err,
    output logic [COUNT_W-1:0] uni_parked_car,
    output logic [COUNT_W-1:0] parked_car,
    output logic [COUNT_W-1:0] uni_vacated_space,
    output logic [COUNT_W-1:0] vacated_space,
    output logic               uni_is_vacated_space,
    output logic               is_vacated_space,
    output logic [HOUR_W-1:0]  hour
);

    if (TOTAL_CAP >= (1 << COUNT_W)) begin : g_bad_count_w
        $error("parking_manager_sched: TOTAL_CAP does not fit in COUNT_W bits");
    end
    if (UNI_CAP_START > TOTAL_CAP) begin : g_bad_uni_cap
        $error("parking_manager_sched: UNI_CAP_START exceeds TOTAL_CAP");
    end

    logic               hour_tick;
    logic [COUNT_W-1:0] uni_cap_q;
    logic [COUNT_W-1:0] uni_cnt;
    logic [COUNT_W-1:0] gen_cnt;
    logic [COUNT_W-1:0] uni_next;
    logic [COUNT_W-1:0] gen_next;
    int                 next_hour;
    int                 uni_cap_i;
    int                 gen_cap_i;
    int                 free_total;
    int                 uni_room;
    int                 gen_room;
    int                 uni_vac_i;
    int                 gen_vac_i;
    cls_e               entry_cls;
    cls_e               exit_cls;
    logic               grant;
    logic               exit_bad;
    logic               uni_inc;
    logic               uni_dec;
    logic               gen_inc;
    logic               gen_dec;

    parking_hour_clock #(
        .CYCLES_PER_HOUR (CYCLES_PER_HOUR),
        .START_HOUR      (START_HOUR)
    ) u_hour_clock (
        .clk       (clk),
        .reset     (reset),
        .hour      (hour),
        .hour_tick (hour_tick)
    );

    assign entry_cls = entry_is_uni ? CLS_UNI : CLS_GEN;
    assign exit_cls  = exit_is_uni  ? CLS_UNI : CLS_GEN;

    // Hour that the clock moves to on its next tick, used to preload the cap.
    always_comb begin
        next_hour = (int'(hour) == HOURS_PER_DAY - 1) ? 0 : int'(hour) + 1;
    end

    // University capacity register, reloaded on the same edge the hour changes
    // so it always matches the displayed hour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uni_cap_q <= COUNT_W'(uni_cap_of_hour(START_HOUR, UNI_CAP_START,
                                                  UNI_CAP_STEP, UNI_CAP_END, STEP_HOUR));
        end else if (hour_tick) begin
            uni_cap_q <= COUNT_W'(uni_cap_of_hour(next_hour, UNI_CAP_START,
                                                  UNI_CAP_STEP, UNI_CAP_END, STEP_HOUR));
        end
    end

    // Free space per class: the class headroom limited by the lot's total free
    // space, clamped at zero when a class is above its (shrunken) capacity.
    always_comb begin
        uni_cap_i  = int'(uni_cap_q);
        gen_cap_i  = TOTAL_CAP - uni_cap_i;
        free_total = TOTAL_CAP - int'(uni_cnt) - int'(gen_cnt);
        uni_room   = uni_cap_i - int'(uni_cnt);
        gen_room   = gen_cap_i - int'(gen_cnt);
        uni_vac_i  = (uni_room < free_total) ? uni_room : free_total;
        gen_vac_i  = (gen_room < free_total) ? gen_room : free_total;
        if (uni_vac_i < 0) begin
            uni_vac_i = 0;
        end
        if (gen_vac_i < 0) begin
            gen_vac_i = 0;
        end
    end

    assign uni_vacated_space    = COUNT_W'(uni_vac_i);
    assign vacated_space        = COUNT_W'(gen_vac_i);
    assign uni_is_vacated_space = (uni_vacated_space != '0);
    assign is_vacated_space     = (vacated_space != '0);
    assign uni_parked_car       = uni_cnt;
    assign parked_car           = gen_cnt;

    // Admission and exit decisions from the pre-edge counts; an exit in the
    // same cycle never frees space for the simultaneous entry.
    always_comb begin
        grant    = 1'b0;
        exit_bad = 1'b0;
        uni_inc  = 1'b0;
        uni_dec  = 1'b0;
        gen_inc  = 1'b0;
        gen_dec  = 1'b0;
        if (entry_req) begin
            if (entry_cls == CLS_UNI) begin
                grant   = uni_is_vacated_space;
                uni_inc = uni_is_vacated_space;
            end else begin
                grant   = is_vacated_space;
                gen_inc = is_vacated_space;
            end
        end
        if (exit_req) begin
            if (exit_cls == CLS_UNI) begin
                exit_bad = (uni_cnt == '0);
                uni_dec  = (uni_cnt != '0);
            end else begin
                exit_bad = (gen_cnt == '0);
                gen_dec  = (gen_cnt != '0);
            end
        end
        uni_next = uni_cnt + COUNT_W'(uni_inc) - COUNT_W'(uni_dec);
        gen_next = gen_cnt + COUNT_W'(gen_inc) - COUNT_W'(gen_dec);
    end

    // Occupancy counters and the one-cycle handshake responses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uni_cnt       <= '0;
            gen_cnt       <= '0;
            entry_ack     <= 1'b0;
            entry_granted <= 1'b0;
            exit_err      <= 1'b0;
        end else begin
            uni_cnt       <= uni_next;
            gen_cnt       <= gen_next;
            entry_ack     <= entry_req;
            entry_granted <= grant;
            exit_err      <= exit_bad;
        end
    end

endmodule
